ram_arbiter: RTL

Two-port round-robin arbiter and sequencer for the single-port, half-duplex 32×16 RAM. It accepts independent read/write requests from two requesters and serialises them onto the RAM's `r_w`/`addr`/`d_in` inputs. It captures the registered RAM read data and returns it with a one-cycle acknowledge. It sits between the RAM and its two clients; the RAM's own `rst` input is tied low at the top level.

---
 rtl/ram_arb_pkg.sv | 21 ++
 rtl/ram_arbiter_rr_arb2.sv | 17 +
 rtl/ram_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants and FSM state encoding for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int DEPTH = 32'd1 << AW;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_CAPT   = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    // Port index (0/1) encoded by a one-hot two-bit grant.
    function automatic logic grant_port(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Combinational two-requester round-robin picker; `last` is the port granted most recently.
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] grant
);
    import ram_arb_pkg::*;

    // A lone request always wins; on contention the port other than `last` wins.
    always_comb begin
        grant    = 2'b00;
        grant[0] = req0 & (~req1 | last);
        grant[1] = req1 & (~req0 | ~last);
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer serialising two clients onto a single-port 32x16 RAM.
// Optional power-up clear of the RAM is built when RAM_ARB_CLEAR_EN is defined.
module ram_arbiter #(
    parameter int AW = ram_arb_pkg::AW,
    parameter int DW = ram_arb_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_r_w,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_d_in,
    input  logic [DW-1:0] mem_d_out,
    output logic          busy
);
    import ram_arb_pkg::*;

`ifdef RAM_ARB_CLEAR_EN
    localparam state_t        RESET_STATE = ST_CLEAR;
    localparam logic          RESET_BUSY  = 1'b1;
    localparam logic [AW-1:0] LAST_ADDR   = {AW{1'b1}};
`else
    localparam state_t        RESET_STATE = ST_IDLE;
    localparam logic          RESET_BUSY  = 1'b0;
`endif

    state_t        state_r, state_s;
    logic          last_r, last_s;
    logic          port_r, port_s;
    logic          write_r, write_s;
    logic          ack0_r, ack0_s;
    logic          ack1_r, ack1_s;
    logic [DW-1:0] rdata0_r, rdata0_s;
    logic [DW-1:0] rdata1_r, rdata1_s;
    logic          mem_r_w_r, mem_r_w_s;
    logic [AW-1:0] mem_addr_r, mem_addr_s;
    logic [DW-1:0] mem_d_in_r, mem_d_in_s;
    logic          busy_r, busy_s;
    logic [1:0]    grant_s;

    rr_arb2 u_pick (
        .req0  (req0),
        .req1  (req1),
        .last  (last_r),
        .grant (grant_s)
    );

    // State and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= RESET_STATE;
            last_r     <= 1'b1;
            port_r     <= 1'b0;
            write_r    <= 1'b0;
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
            rdata0_r   <= {DW{1'b0}};
            rdata1_r   <= {DW{1'b0}};
            mem_r_w_r  <= 1'b0;
            mem_addr_r <= {AW{1'b0}};
            mem_d_in_r <= {DW{1'b0}};
            busy_r     <= RESET_BUSY;
        end else begin
            state_r    <= state_s;
            last_r     <= last_s;
            port_r     <= port_s;
            write_r    <= write_s;
            ack0_r     <= ack0_s;
            ack1_r     <= ack1_s;
            rdata0_r   <= rdata0_s;
            rdata1_r   <= rdata1_s;
            mem_r_w_r  <= mem_r_w_s;
            mem_addr_r <= mem_addr_s;
            mem_d_in_r <= mem_d_in_s;
            busy_r     <= busy_s;
        end
    end

    // Next-state and next-output logic; ack defaults low so it only pulses for one cycle.
    always_comb begin
        state_s    = state_r;
        last_s     = last_r;
        port_s     = port_r;
        write_s    = write_r;
        ack0_s     = 1'b0;
        ack1_s     = 1'b0;
        rdata0_s   = rdata0_r;
        rdata1_s   = rdata1_r;
        mem_r_w_s  = mem_r_w_r;
        mem_addr_s = mem_addr_r;
        mem_d_in_s = mem_d_in_r;

        case (state_r)
            ST_CLEAR: begin
`ifdef RAM_ARB_CLEAR_EN
                mem_d_in_s = {DW{1'b0}};
                if (mem_r_w_r && (mem_addr_r == LAST_ADDR)) begin
                    mem_r_w_s = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    mem_r_w_s  = 1'b1;
                    mem_addr_s = mem_r_w_r ? (mem_addr_r + {{(AW-1){1'b0}}, 1'b1}) : {AW{1'b0}};
                end
`else
                mem_r_w_s = 1'b0;
                state_s   = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                mem_r_w_s = 1'b0;
                if (grant_s != 2'b00) begin
                    port_s     = grant_port(grant_s);
                    last_s     = grant_port(grant_s);
                    write_s    = grant_port(grant_s) ? we1 : we0;
                    mem_r_w_s  = grant_port(grant_s) ? we1 : we0;
                    mem_addr_s = grant_port(grant_s) ? addr1 : addr0;
                    mem_d_in_s = grant_port(grant_s) ? wdata1 : wdata0;
                    state_s    = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // The RAM acts on the edge closing this cycle; drop the write strobe with it.
                mem_r_w_s = 1'b0;
                if (write_r) begin
                    ack0_s  = ~port_r;
                    ack1_s  = port_r;
                    state_s = ST_ACK;
                end else begin
                    state_s = ST_CAPT;
                end
            end
            ST_CAPT: begin
                if (port_r) begin
                    rdata1_s = mem_d_out;
                end else begin
                    rdata0_s = mem_d_out;
                end
                ack0_s  = ~port_r;
                ack1_s  = port_r;
                state_s = ST_ACK;
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                mem_r_w_s = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    assign ack0     = ack0_r;
    assign ack1     = ack1_r;
    assign rdata0   = rdata0_r;
    assign rdata1   = rdata1_r;
    assign mem_r_w  = mem_r_w_r;
    assign mem_addr = mem_addr_r;
    assign mem_d_in = mem_d_in_r;
    assign busy     = busy_r;

endmodule
